lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Sequencer for an HD44780-compatible character LCD in 8-bit mode (16x2). After reset it performs the power-on wait and the fixed initialization command sequence. It then accepts character and command bytes from a host over a valid/ready handshake and generates correctly timed `lcd_rs`, `lcd_data` and `lcd_e` strobes. It replaces free-running, E-clocked display logic: the block runs on the full system clock, and all LCD timing comes from internal counters.

## Interface
- `POR_WAIT`, default 2000000: clocks to wait after reset before the first command (40 ms at 50 MHz).
- `E_CYCLES`, default 25: width of the `lcd_e` high pulse, in clocks.
- `CMD_WAIT`, default 2500: post-strobe wait for ordinary commands and data, in clocks.
- `CLR_WAIT`, default 100000: post-strobe wait for clear/home commands (0x01, 0x02, 0x03), in clocks.
- `inClk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `wr_valid` input 1: host has a byte to send.
- `wr_rs` input 1: 0 = command, 1 = character data.
- `wr_data` input 8: byte to send.
- `wr_ready` output 1: block can accept a byte this cycle.
- `init_done` output 1: initialization sequence has completed.
- `lcd_rs` output 1: LCD register select.
- `lcd_e` output 1: LCD enable strobe.
- `lcd_data` output 8: LCD data bus.

## Operation
- **States:** POR, INIT, IDLE, SETUP, EHIGH, HOLD, WAIT, WRAP.
- **Reset values:** all outputs 0; state POR; cursor position 0; init index 0.
- **POR:** counts `POR_WAIT` clocks, then goes to INIT.
- **INIT:** issues 0x38, 0x0C, 0x06, 0x01 in order, with rs=0.
  - Each command goes through SETUP → EHIGH → HOLD → WAIT.
  - 0x01 uses `CLR_WAIT`.
  - After the fourth WAIT: `init_done`=1 (stays 1 until reset), state IDLE.
- **IDLE:** `wr_ready`=1. A transfer occurs on a clock edge with `wr_valid`&&`wr_ready`.
  - At that edge, `lcd_rs`/`lcd_data` load `wr_rs`/`wr_data`, `wr_ready` drops, and the state goes to SETUP.
- **SETUP:** 1 clock, with `lcd_e`=0 and rs/data stable.
- **EHIGH:** `lcd_e`=1 for exactly `E_CYCLES` clocks.
- **HOLD:** 1 clock, with `lcd_e`=0 and rs/data unchanged.
- **WAIT:** lasts `CLR_WAIT` clocks if rs=0 and the byte is in 0x01..0x03; otherwise `CMD_WAIT` clocks.
- **Cursor position `pos`:** 5-bit, 0–15 = line 1, 16–31 = line 2.
  - rs=1 byte: `pos` increments after the strobe.
  - rs=0 byte in 0x01..0x03: `pos` = 0.
  - rs=0 byte with bit 7 set: `pos` = {data[6], data[3:0]}.
  - All other commands leave `pos` unchanged.
- **Exit from WAIT:** goes to WRAP if a wrap is pending (see Configuration); otherwise to IDLE.
- **WRAP:** issues an internal rs=0 address command through SETUP/EHIGH/HOLD/WAIT using `CMD_WAIT`, then returns to IDLE.
- **Bus hold:** `lcd_rs`/`lcd_data` keep their last driven value while in IDLE.
- **Host requests outside IDLE:** ignored; the host holds `wr_valid` and data until it sees `wr_ready`.
- **Reset mid-transfer:** `lcd_e` drops immediately (asynchronously), outputs clear, and the full POR/INIT sequence restarts. No partial transfer resumes.

## Timing
- `wr_ready` is high only in IDLE with `init_done`=1, and never in the same cycle as `lcd_e`.
- Accept to `lcd_e` rise: 1 clock (SETUP).
- `lcd_e` high: `E_CYCLES` clocks.
- Accept to next `wr_ready`: 2+`E_CYCLES`+wait clocks. A wrap command adds a further 2+`E_CYCLES`+`CMD_WAIT` clocks.
- Back-to-back: if `wr_valid` is held, the next byte is accepted on the first cycle `wr_ready` is high.
- Counters are wide enough for the parameter values; zero-valued waits are not supported (minimum 1).

## Configuration
- `LCD_AUTOWRAP_EN` defined:
  - A data write that moves `pos` from 15 to 16 inserts command 0xC0.
  - A data write that moves `pos` from 31 to 32 sets `pos`=0 and inserts command 0x80.
- `LCD_AUTOWRAP_EN` not defined:
  - WRAP is never entered.
  - `pos` still tracks but simply wraps mod 32, and no commands are inserted.

## Test plan
Use `POR_WAIT`=10, `E_CYCLES`=2, `CMD_WAIT`=4, `CLR_WAIT`=8.
- **Init:** release reset, no host traffic.
  - `lcd_data` shows 0x38, 0x0C, 0x06, 0x01, each with rs=0 and a 2-clock E pulse.
  - `init_done` and `wr_ready` rise 10 + 3×8 + 12 = 46 clocks after reset release.
- **Single character:** write rs=1, 0x41.
  - `lcd_e` rises 1 clock after accept, with `lcd_data`=0x41 and `lcd_rs`=1.
  - `wr_ready` returns 8 clocks after accept.
- **Clear timing:** write rs=0, 0x01.
  - `wr_ready` returns 12 clocks after accept, and the internal `pos` = 0.
- **Autowrap (macro defined):** write 16 characters back-to-back.
  - After the 16th, an rs=0 0xC0 strobe appears before `wr_ready`.
  - 16 more characters produce 0x80.
  - With the macro undefined, no rs=0 strobes appear.
- **Reset mid-strobe:** assert `reset` while `lcd_e`=1.
  - `lcd_e`, `lcd_rs`, `lcd_data`, `wr_ready` and `init_done` go to 0 immediately.
  - After release, the full init sequence repeats.
- **Held request:** hold `wr_valid` during init and during a transfer.
  - No accept occurs while `wr_ready`=0.
  - Exactly one accept occurs per IDLE entry.

Source files
------------

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 8-bit LCD sequencer; define LCD_AUTOWRAP_EN for automatic line wrap
module lcd_ctrl #(
    parameter int POR_WAIT = 2000000,
    parameter int E_CYCLES = 25,
    parameter int CMD_WAIT = 2500,
    parameter int CLR_WAIT = 100000
) (
    input  logic       inClk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    typedef enum logic [2:0] {POR, INIT, IDLE, SETUP, EHIGH, HOLD, WAIT, WRAP} state_t;

    localparam logic [31:0] POR_LAST = 32'(POR_WAIT - 1);
    localparam logic [31:0] E_LAST   = 32'(E_CYCLES - 1);
    localparam logic [31:0] CMD_LAST = 32'(CMD_WAIT - 1);
    localparam logic [31:0] CLR_LAST = 32'(CLR_WAIT - 1);

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] wait_last;
    logic [1:0]  init_idx;
    logic [4:0]  pos;
    logic        wrap_pend;
    logic [7:0]  wrap_cmd;

    logic        is_clr;
    logic [4:0]  pos_next;
    logic        wrap_set;
    logic [7:0]  wrap_cmd_next;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    assign is_clr = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03);

    // Cursor tracking for the byte currently on the bus, applied once its strobe completes.
    always_comb begin
        pos_next      = pos;
        wrap_set      = 1'b0;
        wrap_cmd_next = 8'h80;
        if (lcd_rs) begin
`ifdef LCD_AUTOWRAP_EN
            if (pos == 5'd15) begin
                pos_next      = 5'd16;
                wrap_set      = 1'b1;
                wrap_cmd_next = 8'hC0;
            end else if (pos == 5'd31) begin
                pos_next      = 5'd0;
                wrap_set      = 1'b1;
                wrap_cmd_next = 8'h80;
            end else begin
                pos_next = pos + 5'd1;
            end
`else
            pos_next = pos + 5'd1;
`endif
        end else if (is_clr) begin
            pos_next = 5'd0;
        end else if (lcd_data[7]) begin
            pos_next = {lcd_data[6], lcd_data[3:0]};
        end
    end

    // INIT and WRAP double as the one-clock setup cycle of internally generated commands.
    always_ff @(posedge inClk or negedge reset) begin
        if (!reset) begin
            state     <= POR;
            cnt       <= '0;
            wait_last <= '0;
            init_idx  <= '0;
            pos       <= '0;
            wrap_pend <= 1'b0;
            wrap_cmd  <= '0;
            wr_ready  <= 1'b0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= '0;
        end else begin
            case (state)
                POR: begin
                    if (cnt == POR_LAST) begin
                        cnt      <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_cmd(2'd0);
                        state    <= INIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                INIT, SETUP, WRAP: begin
                    cnt   <= '0;
                    lcd_e <= 1'b1;
                    state <= EHIGH;
                end
                IDLE: begin
                    if (wr_valid && wr_ready) begin
                        lcd_rs   <= wr_rs;
                        lcd_data <= wr_data;
                        wr_ready <= 1'b0;
                        state    <= SETUP;
                    end
                end
                EHIGH: begin
                    if (cnt == E_LAST) begin
                        lcd_e <= 1'b0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLD: begin
                    cnt       <= '0;
                    wait_last <= is_clr ? CLR_LAST : CMD_LAST;
                    pos       <= pos_next;
                    if (wrap_set) begin
                        wrap_pend <= 1'b1;
                        wrap_cmd  <= wrap_cmd_next;
                    end
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (!init_done) begin
                            if (init_idx == 2'd3) begin
                                init_done <= 1'b1;
                                wr_ready  <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                lcd_data <= init_cmd(init_idx + 2'd1);
                                state    <= INIT;
                            end
                        end else if (wrap_pend) begin
                            wrap_pend <= 1'b0;
                            lcd_rs    <= 1'b0;
                            lcd_data  <= wrap_cmd;
                            state     <= WRAP;
                        end else begin
                            wr_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= POR;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - randomized self-checking bench for lcd_ctrl against a transaction-level model
module tb_lcd_ctrl;

    localparam int POR = 10;
    localparam int E   = 2;
    localparam int CMD = 4;
    localparam int CLR = 8;
    localparam int INIT_T  = POR + 3 * (2 + E + CMD) + (2 + E + CLR);
    localparam int BOUND   = 400;

    logic       inClk;
    logic       reset;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_e;
    logic [7:0] lcd_data;

    lcd_ctrl #(
        .POR_WAIT(POR),
        .E_CYCLES(E),
        .CMD_WAIT(CMD),
        .CLR_WAIT(CLR)
    ) dut (
        .inClk(inClk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_rs(wr_rs),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .init_done(init_done),
        .lcd_rs(lcd_rs),
        .lcd_e(lcd_e),
        .lcd_data(lcd_data)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int mpos = 0;
    int n_sends = 0;
    int last_wait = 0;

    int acc_mon = 0;
    int overlap = 0;
    int bad_ready = 0;
    int bad_width = 0;
    int cmd_strobes = 0;
    int e_run = 0;
    logic prev_e = 1'b0;
    logic [8:0] e_tag = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observe the LCD bus: one entry per E strobe, plus protocol sanity counters.
    always @(negedge inClk) begin
        if (!reset) begin
            e_run  = 0;
            prev_e = 1'b0;
        end else begin
            if (lcd_e && wr_ready) overlap++;
            if (wr_ready && !init_done) bad_ready++;
            if (wr_valid && wr_ready) acc_mon++;
            if (lcd_e) begin
                if (!prev_e) begin
                    obs_q.push_back({lcd_rs, lcd_data});
                    e_tag = {lcd_rs, lcd_data};
                    if (!lcd_rs) cmd_strobes++;
                end
                e_run++;
            end else if (prev_e) begin
                if (e_run != E) bad_width++;
                if ({lcd_rs, lcd_data} != e_tag) bad_width++;
                e_run = 0;
            end
            prev_e = lcd_e;
        end
    end

    task automatic model_reset();
        exp_q.delete();
        obs_q.delete();
        mpos = 0;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic model_write(input logic rs, input logic [7:0] d, output int lat);
        bit clr;
        clr = !rs && d >= 8'h01 && d <= 8'h03;
        lat = 2 + E + (clr ? CLR : CMD);
        exp_q.push_back({rs, d});
        if (rs) begin
            mpos = mpos + 1;
`ifdef LCD_AUTOWRAP_EN
            if (mpos == 16) begin
                exp_q.push_back({1'b0, 8'hC0});
                lat = lat + 2 + E + CMD;
            end else if (mpos == 32) begin
                mpos = 0;
                exp_q.push_back({1'b0, 8'h80});
                lat = lat + 2 + E + CMD;
            end
`else
            mpos = mpos % 32;
`endif
        end else if (clr) begin
            mpos = 0;
        end else if (d[7]) begin
            mpos = (d[6] ? 16 : 0) + int'(d[3:0]);
        end
    endtask

    task automatic drain();
        check("strobe_count", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check("strobe", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where wr_ready comes back.
    task automatic send(input logic rs, input logic [7:0] d, input bit keep);
        int lat;
        int w;
        int k;
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        w = 0;
        while (!wr_ready && w < BOUND) begin
            @(posedge inClk);
            #1;
            w++;
        end
        last_wait = w;
        check("ready_seen", wr_ready, 1);
        if (!wr_ready) begin
            wr_valid = 1'b0;
            return;
        end
        model_write(rs, d, lat);
        @(posedge inClk);
        #1;
        n_sends++;
        check("setup_e_low", {lcd_e, wr_ready}, 2'b00);
        if (!keep) wr_valid = 1'b0;
        @(posedge inClk);
        #1;
        check("e_rise", {lcd_e, lcd_rs, lcd_data}, {1'b1, rs, d});
        k = 1;
        while (!wr_ready && k < BOUND) begin
            @(posedge inClk);
            #1;
            k++;
        end
        check("latency", k, lat);
        drain();
        check("pos", 32'(dut.pos), mpos);
    endtask

    task automatic send_random(input int n);
        logic       rs;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 255));
            send(rs, d, 1'b0);
        end
    endtask

    initial begin
        int k;
        int base;
        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = '0;

        repeat (3) @(posedge inClk);
        #1;
        check("reset_outputs", {lcd_e, lcd_rs, lcd_data, wr_ready, init_done}, 0);

        reset = 1'b1;
        model_reset();
        k = 0;
        while (!init_done && k < BOUND) begin
            @(posedge inClk);
            #1;
            k++;
        end
        check("init_time", k, INIT_T);
        check("init_ready", wr_ready, 1);
        drain();
        check("init_pos", 32'(dut.pos), 0);

        send(1'b1, 8'h41, 1'b0);
        send(1'b0, 8'h01, 1'b0);

        send_random(30);

        // Fill both lines back-to-back with wr_valid held between bytes.
        send(1'b0, 8'h01, 1'b0);
        base = cmd_strobes;
        for (int i = 0; i < 32; i++)
            send(1'b1, 8'(8'h30 + i), i != 31);
        wr_valid = 1'b0;
`ifdef LCD_AUTOWRAP_EN
        check("wrap_cmds", cmd_strobes - base, 2);
`else
        check("wrap_cmds", cmd_strobes - base, 0);
`endif

        // Reset while E is high, with a request held across the whole re-init.
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h5A;
        @(posedge inClk);
        #1;
        n_sends++;
        @(posedge inClk);
        #1;
        check("pre_reset_e", lcd_e, 1);
        #2;
        reset   = 1'b0;
        wr_data = 8'h42;
        #1;
        check("reset_async", {lcd_e, lcd_rs, lcd_data, wr_ready, init_done}, 0);
        repeat (2) @(posedge inClk);
        #1;
        reset = 1'b1;
        model_reset();
        send(1'b1, 8'h42, 1'b0);
        check("held_init_wait", last_wait, INIT_T);

        send_random(10);

        check("e_width_or_bus_change", bad_width, 0);
        check("ready_with_e", overlap, 0);
        check("ready_before_init", bad_ready, 0);
        check("accept_count", acc_mon, n_sends);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
